trade_report_tx: RTL

TRADE_REPORT_TX -- requirements
Module: trade_report_tx

---
 rtl/hft_pkg.sv | 23 ++
 rtl/hft_sync_fifo.sv | 63 ++++++
 rtl/trade_report_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
// Shared definitions for the trade report transmit path: header tag, frame FSM
// states, frame length and the frame word helpers.
package hft_pkg;

  localparam logic [15:0] MAGIC_DEFAULT = 16'h5452;
  localparam int          FRAME_WORDS   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } tx_state_t;

  function automatic logic [31:0] frame_hdr(input logic [15:0] magic, input logic [15:0] seq);
    return {magic, seq};
  endfunction

  function automatic logic [31:0] frame_csum(input logic [31:0] hdr, input logic [31:0] data);
    return hdr ^ data;
  endfunction

endpackage

// File: rtl/hft_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module hft_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/trade_report_tx.sv
// Buffers executed trades and frames each one as HDR/DATA/CSUM words on a
// valid/ready stream, counting trades lost to overflow.
module trade_report_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MAGIC      = hft_pkg::MAGIC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 trade_data,
  input  logic                        trade_valid,
  output logic [31:0]                 tcp_tx_data,
  output logic                        tcp_tx_valid,
  input  logic                        tcp_tx_ready,
  output logic                        tcp_tx_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 drop_count
);

  import hft_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state_r;
  logic [15:0]    seq_r;
  logic [31:0]    entry_r;
  logic [31:0]    data_r;
  logic           valid_r;
  logic           last_r;
  logic           pend_r;
  logic [15:0]    drop_r;

  logic [31:0]    fifo_dout_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [LW-1:0]  fifo_level_s;
  logic           push_s;
  logic           pop_s;
  logic           drop_s;

  assign push_s = trade_valid && !rst;
  assign pop_s  = valid_r && tcp_tx_ready && (state_r == ST_DATA);
  assign drop_s = push_s && fifo_full_s && !pop_s;

  hft_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (trade_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Frame sequencer. pend_r delays the IDLE exit by one cycle so a fresh trade
  // reaches the wire two edges after it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      seq_r   <= 16'h0000;
      entry_r <= 32'h0000_0000;
      data_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      pend_r <= !fifo_empty_s;
      case (state_r)
        ST_IDLE: begin
          if (pend_r && !fifo_empty_s) begin
            state_r <= ST_HDR;
            data_r  <= frame_hdr(MAGIC, seq_r);
            valid_r <= 1'b1;
            last_r  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (tcp_tx_ready) begin
            state_r <= ST_DATA;
            entry_r <= fifo_dout_s;
            data_r  <= fifo_dout_s;
          end
        end
        ST_DATA: begin
          if (tcp_tx_ready) begin
            state_r <= ST_CSUM;
            data_r  <= frame_csum(frame_hdr(MAGIC, seq_r), entry_r);
            last_r  <= 1'b1;
          end
        end
        ST_CSUM: begin
          if (tcp_tx_ready) begin
            seq_r  <= seq_r + 16'd1;
            last_r <= 1'b0;
            if (!fifo_empty_s) begin
              state_r <= ST_HDR;
              data_r  <= frame_hdr(MAGIC, seq_r + 16'd1);
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              data_r  <= 32'h0000_0000;
              valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          data_r  <= 32'h0000_0000;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Overflow counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 16'h0000;
    end else if (drop_s && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'd1;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign tcp_tx_data  = data_r;
  assign tcp_tx_valid = valid_r;
  assign tcp_tx_last  = last_r;
  assign fifo_level   = fifo_level_s;
  assign drop_count   = drop_r;

endmodule
